if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word fetches over a req/ack instruction-memory port that tolerates wait states.
- Presents {instr, pc_4} to IF/ID every cycle, with a valid flag, and inserts NOP bubbles when no instruction is available.
- Honours hazard-unit stalls through a one-entry skid buffer, and honours branch/jump redirects by flushing its output and abandoning in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- NOP_INSTR, 32'h0000_0000, instruction word emitted as a bubble (sll $0,$0,0).

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit holds IF; output is consumed on a posedge where stall=0.
- redirect  input  1  taken branch or jump; flush and refetch.
- redirect_pc  input  32  redirect target; bits [1:0] forced to 0.
- imem_req  output  1  fetch request; while high, imem_addr is held stable until imem_ack.
- imem_addr  output  32  word address being fetched.
- imem_ack  input  1  imem_rdata valid this cycle; completes the current request.
- imem_rdata  input  32  fetched instruction.
- instr  output  32  instruction to IF/ID (registered).
- pc_4  output  32  PC+4 of instr (registered).
- fetch_valid  output  1  1 = instr is real; 0 = bubble.

Behaviour:
- Reset: state=FETCH; pc=RESET_PC; instr=NOP_INSTR; pc_4=0; fetch_valid=0; skid empty; drain_addr=0. Reset overrides all other inputs, including mid-request; the memory is reset together with this block.
- Combinational outputs:
  - imem_req=1 in FETCH and DRAIN, 0 in SKID.
  - imem_addr=pc in FETCH, drain_addr in DRAIN.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Output update on every posedge (rst=0):
  - Output is "free" when fetch_valid=0 or stall=0.
  - If free and a capture occurs: output <= {rdata, pc+4, 1}.
  - If free and no capture: output <= {NOP_INSTR, 0, 0}.
  - Else: output held.
- FETCH, redirect=0:
  - ack and free: capture to output; pc<=pc+4; stay in FETCH. Latency is 1 cycle after ack.
  - ack and not free: skid<={rdata, pc+4}; pc<=pc+4; go to SKID.
  - no ack: pc held; stay in FETCH.
- SKID, redirect=0:
  - stall=0: output<={skid, 1}; go to FETCH.
  - stall=1: hold.
- DRAIN, redirect=0: output goes bubble when free.
  - ack: discard data; go to FETCH.
  - no ack: stay in DRAIN.
- redirect=1 has priority over stall in every state:
  - pc<=redirect_pc; output<=bubble regardless of stall; skid cleared.
  - FETCH with no ack: drain_addr<=pc; go to DRAIN.
  - FETCH with ack: data discarded; stay in FETCH.
  - SKID: go to FETCH.
  - DRAIN with ack: go to FETCH.
  - DRAIN with no ack: stay in DRAIN; pc takes the newest target.
- Invariants:
  - Never two instructions in flight.
  - The skid never overwrites a valid output.
  - No instruction is lost or duplicated under stall.

Decomposition:
- Shared package if_pkg holds:
  - NOP_INSTR constant and RESET_PC default.
  - State encoding: FETCH=2'd0, SKID=2'd1, DRAIN=2'd2.
  - Fetch-bundle typedef {instr[31:0], pc_4[31:0], valid}.
- One sub-module is natural: fetch_skid_buf. It is a one-entry bundle register with load, clear and full flag, and it is reused by later decoupled stages.
- FSM and PC remain in if_fetch_stage.

Test Plan:
- Zero-wait sequential fetch: rst for 2 cycles, then ack every cycle with rdata=0x20080001, 0x20090002, ...
  - Expected: imem_addr = 0, 4, 8 on successive cycles.
  - Expected: output {0x20080001, pc_4=4, valid=1} one cycle after the first ack.
- Wait states: ack only every third cycle.
  - Expected: two bubbles (instr=0, valid=0) between valid outputs.
  - Expected: imem_addr stable at 0x4 while req is pending.
- Stall with skid:
  - Stimulus: output valid at pc_4=0x8, stall=1 for 3 cycles, ack arrives with 0xAAAA0000.
  - Expected: state enters SKID and imem_req drops; output stays at 0x8 while stalled.
  - Expected: after stall drops, output is 0xAAAA0000 with pc_4=0xC, followed by the fetch at 0xC.
- Redirect mid-request:
  - Stimulus: FETCH pending at 0x10 with no ack; pulse redirect with redirect_pc=0x400.
  - Expected: DRAIN holds addr 0x10 until ack, and that data is discarded.
  - Expected: next request is at 0x400; output shows a bubble immediately after the redirect.
- Redirect during stall with a full skid:
  - Expected: skid and output flushed to bubble at the next posedge; next request at redirect_pc.
- PC wrap and reset mid-operation:
  - Stimulus: pc=0xFFFFFFFC, ack 0x12345678.
  - Expected: pc_4=0; next imem_addr=0.
  - Stimulus: assert rst during DRAIN.
  - Expected: next cycle is FETCH at RESET_PC with valid=0.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its skid buffer.
package if_pkg;

  // sll $0,$0,0 is the canonical MIPS bubble.
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    SKID  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_4;
    logic        valid;
  } fetch_bundle_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge port.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry bundle register used to park a fetched instruction while the
// downstream register is stalled. Clear wins over load.
module fetch_skid_buf
  import if_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  fetch_bundle_t din,
  output fetch_bundle_t dout,
  output logic          full
);

  fetch_bundle_t data_q;

  // Entry register: empty after reset or clear, captures din on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (clear) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= din;
    end
  end

  assign dout = data_q;
  assign full = data_q.valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack port with
// wait states, and feeds the IF/ID register with bubbles when empty.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   FETCH | request outstanding at pc; ack delivers the instruction
//   SKID  | instruction parked in skid buffer while IF/ID is stalled
//   DRAIN | waiting out an abandoned request at drain_addr after redirect
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  if_fetch_stage_if.master   imem,
  output logic [31:0]        instr,
  output logic [31:0]        pc_4,
  output logic               fetch_valid
);

  localparam fetch_bundle_t BUBBLE = '{instr: NOP_INSTR, pc_4: 32'h0, valid: 1'b0};

  fetch_state_e  state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [31:0]   drain_addr, drain_nxt;
  logic [31:0]   pc_plus4;
  fetch_bundle_t out_q, out_nxt;
  fetch_bundle_t skid_q, skid_din;
  logic          skid_load, skid_clear, skid_full;
  logic          free;

  assign pc_plus4 = pc + 32'd4;
  // The IF/ID register can accept new content when it holds a bubble or
  // is being consumed this edge.
  assign free     = !out_q.valid || !stall;
  assign skid_din = '{instr: imem.imem_rdata, pc_4: pc_plus4, valid: 1'b1};

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (skid_din),
    .dout  (skid_q),
    .full  (skid_full)
  );

  // State, PC, drain address and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= 32'h0;
      out_q      <= BUBBLE;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drain_addr <= drain_nxt;
      out_q      <= out_nxt;
    end
  end

  // Next-state, PC and output selection; redirect overrides stall.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    drain_nxt  = drain_addr;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    out_nxt    = free ? BUBBLE : out_q;

    if (redirect) begin
      pc_nxt     = redirect_pc & ~32'h3;
      out_nxt    = BUBBLE;
      skid_clear = 1'b1;
      unique case (state)
        FETCH: begin
          // An unacked request is still owed a response; wait it out.
          if (!imem.imem_ack) begin
            drain_nxt = pc;
            state_nxt = DRAIN;
          end
        end
        SKID:    state_nxt = FETCH;
        DRAIN:   if (imem.imem_ack) state_nxt = FETCH;
        default: state_nxt = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (imem.imem_ack) begin
            pc_nxt = pc_plus4;
            if (free) begin
              out_nxt = skid_din;
            end else begin
              skid_load = 1'b1;
              state_nxt = SKID;
            end
          end
        end
        SKID: begin
          if (!stall) begin
            if (skid_full) out_nxt = skid_q;
            skid_clear = 1'b1;
            state_nxt  = FETCH;
          end
        end
        DRAIN:   if (imem.imem_ack) state_nxt = FETCH;
        default: state_nxt = FETCH;
      endcase
    end
  end

  assign imem.imem_req  = (state != SKID);
  assign imem.imem_addr = (state == DRAIN) ? drain_addr : pc;

  assign instr       = out_q.instr;
  assign pc_4        = out_q.pc_4;
  assign fetch_valid = out_q.valid;

endmodule
